mux_channel_scheduler: RTL
==========================

// Module: mux_channel_scheduler
// PURPOSE
//  Round-robin scheduler for the shared 4:1 select mux in the TDC readout path.
//  Four channels raise level requests. The block drives the mux select pair {x,y}
//  to the winning channel, waits for the mux output to settle, samples it once,
//  and reports the bit with its channel tag. The block sits between the TDC
//  channel front-ends and the capture/serialiser stage.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles select is held stable before sampling mux_z; legal range 1..15
//  CNT_W          4  width of settle counter; must hold SETTLE_CYCLES-1
// PORTS
//  clk           in   1  single system clock, all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  en            in   1  1 = arbitration allowed; 0 = no new grants
//  req           in   4  level request per channel; bit i = channel i
//  mux_z         in   1  output of shared 4:1 mux (00->a ch0, 01->b ch1, 10->c ch2, 11->d ch3)
//  sel_x         out  1  mux select MSB
//  sel_y         out  1  mux select LSB
//  grant         out  4  one-hot grant, held SETTLE..DONE
//  busy          out  1  1 whenever state != IDLE
//  sample_valid  out  1  one-cycle pulse, sample_bit/sample_ch valid
//  sample_bit    out  1  captured mux_z
//  sample_ch     out  2  channel index of sample_bit
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, ptr=0, cnt=0, sel_x=sel_y=0, grant=0,
//   busy=0, sample_valid=0, sample_bit=0, sample_ch=0. All outputs registered.
//  States: IDLE -> SETTLE -> SAMPLE -> DONE -> IDLE.
//  IDLE: if en & |req, winner = first set req[i] scanning i=ptr, ptr+1 .. mod 4.
//   At the edge: {sel_x,sel_y}=winner, grant=1<<winner, cnt=0, go to SETTLE.
//   Otherwise stay in IDLE; sel keeps its last value and grant=0.
//  SETTLE: cnt++ each cycle. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
//   If req[winner] is 0 during SETTLE (abort): go to IDLE, grant=0,
//   no sample_valid, ptr unchanged.
//  SAMPLE: at the edge, sample_bit<=mux_z, sample_ch<=winner, go to DONE.
//   req is not checked in this state.
//  DONE: sample_valid=1 for exactly this cycle. At the edge, ptr<=winner+1
//   (2-bit wrap, 3->0), grant<=0, go to IDLE.
//  Latency: req sampled in IDLE at cycle 0. grant/sel update at cycle 1.
//   sample_valid at cycle SETTLE_CYCLES+2. Transaction period is
//   SETTLE_CYCLES+3 cycles, including at least one IDLE cycle between grants.
//  sel_x/sel_y never change while grant != 0.
//  A new req arriving mid-transaction waits for IDLE. No preemption.
//  en falling mid-transaction: the current transaction completes normally;
//   no new grant is issued while en=0.
//  rst mid-transaction (any state): reset values on the next cycle;
//   no sample_valid for the interrupted transaction.
//  req with more than one bit set: exactly one grant, chosen by the rotating
//   ptr. All-ones req gives grant order 0,1,2,3,0...
// STRUCTURE
//  Package mux_sched_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE, 2-bit
//   encoding); SEL_CH0..SEL_CH3 = 2'b00..2'b11; NUM_CH=4.
//  Sub-module rr_pick4 (combinational): inputs req[3:0], ptr[1:0];
//   outputs any, idx[1:0].
//  The 4:1 mux itself is instantiated outside this block, in the datapath.
// TESTING
//  1 reset: rst=1 for 2 cycles with req=1111 -> all outputs 0, no grant.
//    Release rst -> first grant is ch0.
//  2 single: SETTLE=2, req=0100, mux input c=1 -> cycle1 grant=0100,
//    sel_x=1, sel_y=0; cycle4 sample_valid=1, sample_ch=2, sample_bit=1.
//  3 fairness: req=1111 held for 20 cycles -> grant order 0,1,2,3,
//    period 5 cycles, exactly 4 valid pulses.
//  4 abort: req=0010, drop req[1] at cycle 2 -> grant=0 next cycle,
//    no sample_valid. Re-raise req=1010 -> ch1 granted (ptr unchanged).
//  5 reset mid-op: assert rst in the SAMPLE cycle -> next cycle grant=0,
//    busy=0, no sample_valid pulse.
//  6 enable: en=0, req=0001 for 10 cycles -> no grant. Drop en during
//    SETTLE -> transaction completes with valid; no further grants.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the TDC readout mux scheduler.
// Channel select codes match the external 4:1 mux wiring (a,b,c,d).
package mux_sched_pkg;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    unique case (ch)
      SEL_CH0: oh = 4'b0001;
      SEL_CH1: oh = 4'b0010;
      SEL_CH2: oh = 4'b0100;
      SEL_CH3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic              any,
  output logic [1:0]        idx
);

  logic [1:0] cand;

  // Scan from farthest to nearest so the closest request to ptr wins.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_channel_scheduler.sv
// Round-robin scheduler driving the shared 4:1 mux select, sampling mux_z once
// the select has settled and reporting the bit with its channel tag.
module mux_channel_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  input  logic              mux_z,
  output logic              sel_x,
  output logic              sel_y,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic              sample_valid,
  output logic              sample_bit,
  output logic [1:0]        sample_ch
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_q, win_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              busy_q;
  logic              valid_q, valid_d;
  logic              bit_q, bit_d;
  logic [1:0]        ch_q, ch_d;

  logic              pick_any;
  logic [1:0]        pick_idx;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = 1'b0;
    bit_d   = bit_q;
    ch_d    = ch_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (en && pick_any) begin
          win_d   = pick_idx;
          sel_d   = pick_idx;
          grant_d = ch_onehot(pick_idx);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // A withdrawn request abandons the grant without advancing ptr.
        if (!req[win_q]) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        bit_d   = mux_z;
        ch_d    = win_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = win_q + 2'd1;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SEL_CH0;
      win_q   <= SEL_CH0;
      sel_q   <= SEL_CH0;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      ch_q    <= SEL_CH0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= (state_d != IDLE);
      valid_q <= valid_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
    end
  end

  assign sel_x        = sel_q[1];
  assign sel_y        = sel_q[0];
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_bit   = bit_q;
  assign sample_ch    = ch_q;

endmodule
